// File: rtl/fir_serial_ctrl_if.sv
// Sample, result and coefficient-write bundle for fir_serial_ctrl.
// The slave modport is the filter's view; the master modport is the driver's view.
interface fir_serial_ctrl_if #(
  parameter int unsigned NTAPS = 4,
  parameter int unsigned NB_X  = 8,
  parameter int unsigned NB_C  = 8,
  parameter int unsigned NB_Y  = 8
);
  localparam int unsigned NB_A = $clog2(NTAPS);

  logic            i_valid;
  logic [NB_X-1:0] i_x;
  logic            o_ready;
  logic            o_valid;
  logic [NB_Y-1:0] o_y;
  logic            i_ready;
  logic            i_cfg_we;
  logic [NB_A-1:0] i_cfg_addr;
  logic [NB_C-1:0] i_cfg_data;
  logic            o_cfg_err;

  modport slave (
    input  i_valid, i_x, i_ready, i_cfg_we, i_cfg_addr, i_cfg_data,
    output o_ready, o_valid, o_y, o_cfg_err
  );

  modport master (
    output i_valid, i_x, i_ready, i_cfg_we, i_cfg_addr, i_cfg_data,
    input  o_ready, o_valid, o_y, o_cfg_err
  );
endinterface

// File: rtl/fir_serial_ctrl.sv
// Serial FIR filter: one shared multiplier walks the taps, one tap per cycle.
// The result is rounded half-up, saturated and held until the consumer takes it.
module fir_serial_ctrl #(
  parameter int unsigned NTAPS = 4,
  parameter int unsigned NB_X  = 8,
  parameter int unsigned NBF_X = 6,
  parameter int unsigned NB_C  = 8,
  parameter int unsigned NBF_C = 7,
  parameter int unsigned NB_Y  = 8,
  parameter int unsigned NBF_Y = 6
) (
  input  logic               i_clock,
  input  logic               i_rst_n,
  fir_serial_ctrl_if.slave   bus
);

  localparam int unsigned NB_A   = $clog2(NTAPS);
  localparam int unsigned NB_P   = NB_X + NB_C;
  localparam int unsigned NB_ACC = NB_P + NB_A;
  localparam int unsigned NB_G   = NB_ACC + 1;
  localparam int unsigned SHIFT  = NBF_X + NBF_C - NBF_Y;

  localparam logic signed [NB_G-1:0] RND_HALF = NB_G'(1) << (SHIFT - 1);
  localparam logic signed [NB_G-1:0] Y_MAX    = {{(NB_G-NB_Y+1){1'b0}}, {(NB_Y-1){1'b1}}};
  localparam logic signed [NB_G-1:0] Y_MIN    = {{(NB_G-NB_Y+1){1'b1}}, {(NB_Y-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT
  } state_e;

  state_e                    state_q,   state_d;
  logic [NB_A-1:0]           tap_q,     tap_d;
  logic signed [NB_ACC-1:0]  acc_q,     acc_d;
  logic signed [NB_X-1:0]    x_q [NTAPS];
  logic signed [NB_X-1:0]    x_d [NTAPS];
  logic signed [NB_C-1:0]    c_q [NTAPS];
  logic signed [NB_C-1:0]    c_d [NTAPS];
  logic                      o_ready_q, o_ready_d;
  logic                      o_valid_q, o_valid_d;
  logic [NB_Y-1:0]           o_y_q,     o_y_d;
  logic                      cfg_err_q, cfg_err_d;

  logic signed [NB_P-1:0]    prod;
  logic signed [NB_ACC-1:0]  acc_sum;
  logic signed [NB_G-1:0]    acc_g;
  logic signed [NB_G-1:0]    rnd;
  logic [NB_Y-1:0]           y_sat;

  // Shared MAC and output quantizer; the guard bit absorbs the rounding carry.
  always_comb begin
    prod    = NB_P'(x_q[tap_q]) * NB_P'(c_q[tap_q]);
    acc_sum = acc_q + NB_ACC'(prod);
    acc_g   = NB_G'(acc_sum);
    rnd     = (acc_g + RND_HALF) >>> SHIFT;
    if (rnd > Y_MAX) begin
      y_sat = NB_Y'(Y_MAX);
    end else if (rnd < Y_MIN) begin
      y_sat = NB_Y'(Y_MIN);
    end else begin
      y_sat = rnd[NB_Y-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    acc_d     = acc_q;
    x_d       = x_q;
    c_d       = c_q;
    o_valid_d = o_valid_q;
    o_y_d     = o_y_q;
    cfg_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A write coinciding with an accept lands before the first MAC cycle reads it.
        if (bus.i_cfg_we) begin
          c_d[bus.i_cfg_addr] = bus.i_cfg_data;
        end
        if (bus.i_valid) begin
          x_d[0] = bus.i_x;
          for (int k = 1; k < int'(NTAPS); k++) begin
            x_d[k] = x_q[k-1];
          end
          tap_d   = '0;
          acc_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        cfg_err_d = bus.i_cfg_we;
        acc_d     = acc_sum;
        tap_d     = tap_q + NB_A'(1);
        if (tap_q == NB_A'(NTAPS - 1)) begin
          o_y_d     = y_sat;
          o_valid_d = 1'b1;
          state_d   = S_OUT;
        end
      end
      S_OUT: begin
        cfg_err_d = bus.i_cfg_we;
        if (bus.i_ready) begin
          o_valid_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    o_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      tap_q     <= '0;
      acc_q     <= '0;
      o_ready_q <= 1'b1;
      o_valid_q <= 1'b0;
      o_y_q     <= '0;
      cfg_err_q <= 1'b0;
      for (int k = 0; k < int'(NTAPS); k++) begin
        x_q[k] <= '0;
        c_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      acc_q     <= acc_d;
      o_ready_q <= o_ready_d;
      o_valid_q <= o_valid_d;
      o_y_q     <= o_y_d;
      cfg_err_q <= cfg_err_d;
      for (int k = 0; k < int'(NTAPS); k++) begin
        x_q[k] <= x_d[k];
        c_q[k] <= c_d[k];
      end
    end
  end

  assign bus.o_ready   = o_ready_q;
  assign bus.o_valid   = o_valid_q;
  assign bus.o_y       = o_y_q;
  assign bus.o_cfg_err = cfg_err_q;

endmodule

// File: tb/tb_fir_serial_ctrl.sv
// Scoreboard bench for fir_serial_ctrl: directed corner cases then random traffic,
// expected outputs come from a plain-arithmetic FIR model.
module tb_fir_serial_ctrl;

  localparam int unsigned NTAPS = 4;
  localparam int unsigned NB_X  = 8;
  localparam int unsigned NBF_X = 6;
  localparam int unsigned NB_C  = 8;
  localparam int unsigned NBF_C = 7;
  localparam int unsigned NB_Y  = 8;
  localparam int unsigned NBF_Y = 6;
  localparam int unsigned NB_A  = $clog2(NTAPS);
  localparam int          SH    = int'(NBF_X + NBF_C - NBF_Y);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_serial_ctrl_if #(.NTAPS(NTAPS), .NB_X(NB_X), .NB_C(NB_C), .NB_Y(NB_Y)) bus ();

  fir_serial_ctrl #(
    .NTAPS(NTAPS), .NB_X(NB_X), .NBF_X(NBF_X), .NB_C(NB_C),
    .NBF_C(NBF_C), .NB_Y(NB_Y), .NBF_Y(NBF_Y)
  ) dut (
    .i_clock (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    int y;
    int acc_cyc;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   coef [NTAPS];
  int   hist [NTAPS];
  exp_t exq [$];
  exp_t mon_e;
  bit   fresh   = 1'b1;
  bit   hs_prev = 1'b0;
  int   held_y  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic int sx_x(input int v);
    logic signed [NB_X-1:0] t;
    t = NB_X'(v);
    return int'(t);
  endfunction

  function automatic int sx_c(input int v);
    logic signed [NB_C-1:0] t;
    t = NB_C'(v);
    return int'(t);
  endfunction

  function automatic int sx_y(input logic [NB_Y-1:0] v);
    logic signed [NB_Y-1:0] t;
    t = v;
    return int'(t);
  endfunction

  // Reference: dot product of history and taps, round half up, clamp.
  function automatic int ref_y();
    int s;
    int hi;
    int lo;
    s = 0;
    for (int k = 0; k < int'(NTAPS); k++) s += hist[k] * coef[k];
    s  = (s + (1 << (SH - 1))) >>> SH;
    hi = (1 << (NB_Y - 1)) - 1;
    lo = -(1 << (NB_Y - 1));
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < int'(NTAPS); k++) begin
      coef[k] = 0;
      hist[k] = 0;
    end
    exq.delete();
    fresh   = 1'b1;
    hs_prev = 1'b0;
  endtask

  // One clock of stimulus; the model only acts when the block is idle.
  task automatic drive(input bit v, input int x, input bit we, input int a, input int d, input bit rdy);
    bit   rdy_now;
    bit   exp_err;
    exp_t e;
    bus.i_valid    = v;
    bus.i_x        = NB_X'(x);
    bus.i_cfg_we   = we;
    bus.i_cfg_addr = NB_A'(a);
    bus.i_cfg_data = NB_C'(d);
    bus.i_ready    = rdy;
    rdy_now = bus.o_ready;
    exp_err = we && !rdy_now;
    if (rdy_now && we) coef[a] = sx_c(d);
    if (rdy_now && v) begin
      for (int k = int'(NTAPS) - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0]   = sx_x(x);
      e.y       = ref_y();
      e.acc_cyc = cyc + 1;
      exq.push_back(e);
    end
    @(posedge clk);
    #1;
    check("cfg_err", int'(bus.o_cfg_err), int'(exp_err));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(bus.o_ready === 1'b1 && bus.o_valid === 1'b0) && n < 60) begin
      drive(1'b0, 0, 1'b0, 0, 0, 1'b1);
      n++;
    end
    check("idle_reached", int'(bus.o_ready === 1'b1 && bus.o_valid === 1'b0), 1);
  endtask

  // Monitor: pops the scoreboard on each new result, checks hold while stalled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hs_prev) begin
        check("idle_after_handshake_ready", int'(bus.o_ready), 1);
        check("idle_after_handshake_valid", int'(bus.o_valid), 0);
      end
      hs_prev = 1'b0;
      if (bus.o_valid) begin
        check("out_ready_low", int'(bus.o_ready), 0);
        if (fresh) begin
          if (exq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output got o_y=%0d want no result", sx_y(bus.o_y));
          end else begin
            mon_e = exq.pop_front();
            check("o_y", sx_y(bus.o_y), mon_e.y);
            check("latency", cyc - mon_e.acc_cyc + 1, int'(NTAPS) + 1);
          end
          held_y = sx_y(bus.o_y);
          fresh  = 1'b0;
        end else begin
          check("o_y_stable", sx_y(bus.o_y), held_y);
        end
        if (bus.i_ready) begin
          fresh   = 1'b1;
          hs_prev = 1'b1;
        end
      end
    end
  end

  initial begin
    bus.i_valid    = 1'b0;
    bus.i_x        = '0;
    bus.i_cfg_we   = 1'b0;
    bus.i_cfg_addr = '0;
    bus.i_cfg_data = '0;
    bus.i_ready    = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", int'(bus.o_ready), 1);
    check("reset_valid", int'(bus.o_valid), 0);
    check("reset_y", int'(bus.o_y), 0);
    check("reset_cfg_err", int'(bus.o_cfg_err), 0);
    rst_n = 1'b1;

    // Half times half.
    drive(1'b0, 0, 1'b1, 0, 64, 1'b1);
    drive(1'b1, 32, 1'b0, 0, 0, 1'b1);
    wait_idle();

    // Rounding at exactly one half and just below.
    drive(1'b0, 0, 1'b1, 0, 1, 1'b1);
    drive(1'b1, 64, 1'b0, 0, 0, 1'b1);
    wait_idle();
    drive(1'b1, 32, 1'b0, 0, 0, 1'b1);
    wait_idle();

    // Positive and negative saturation.
    for (int a = 0; a < int'(NTAPS); a++) drive(1'b0, 0, 1'b1, a, 127, 1'b1);
    repeat (4) begin drive(1'b1, 127, 1'b0, 0, 0, 1'b1); wait_idle(); end
    repeat (4) begin drive(1'b1, 128, 1'b0, 0, 0, 1'b1); wait_idle(); end

    // Backpressure with ignored samples, then a sample that exposes the line.
    for (int a = 0; a < int'(NTAPS); a++) drive(1'b0, 0, 1'b1, a, 10 * (a + 1), 1'b1);
    drive(1'b1, 50, 1'b0, 0, 0, 1'b0);
    repeat (NTAPS + 10) drive(1'b1, int'($urandom_range(0, 255)), 1'b0, 0, 0, 1'b0);
    drive(1'b0, 0, 1'b0, 0, 0, 1'b1);
    wait_idle();
    drive(1'b1, 7, 1'b0, 0, 0, 1'b1);
    wait_idle();

    // Rejected write during MAC, then a write coinciding with an accept.
    drive(1'b1, 33, 1'b0, 0, 0, 1'b1);
    drive(1'b0, 0, 1'b1, 0, 99, 1'b1);
    wait_idle();
    drive(1'b1, 21, 1'b1, 1, 206, 1'b1);
    wait_idle();

    // Reset during the second MAC cycle.
    drive(1'b1, 77, 1'b0, 0, 0, 1'b1);
    drive(1'b0, 0, 1'b0, 0, 0, 1'b1);
    rst_n = 1'b0;
    model_reset();
    #3;
    check("midmac_reset_valid", int'(bus.o_valid), 0);
    check("midmac_reset_ready", int'(bus.o_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_valid", int'(bus.o_valid), 0);
    check("post_reset_ready", int'(bus.o_ready), 1);
    drive(1'b1, 100, 1'b0, 0, 0, 1'b1);
    wait_idle();

    // Random traffic.
    repeat (2000) begin
      drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
            bit'($urandom_range(0, 6) == 0), int'($urandom_range(0, NTAPS - 1)),
            int'($urandom_range(0, 255)), bit'($urandom_range(0, 3) != 0));
    end
    wait_idle();
    check("scoreboard_empty", exq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_serial_ctrl.md
FIR_SERIAL_CTRL -- requirements
Module: fir_serial_ctrl

Interface
REQ-001 SHALL have parameter NTAPS, default 4, meaning number of filter taps (power of two, >=2).
REQ-002 SHALL have parameter NB_X, default 8, meaning input sample width (signed, S(8,6)).
REQ-003 SHALL have parameter NBF_X, default 6, meaning input sample fractional bits.
REQ-004 SHALL have parameter NB_C, default 8, meaning coefficient width (signed, S(8,7)).
REQ-005 SHALL have parameter NBF_C, default 7, meaning coefficient fractional bits.
REQ-006 SHALL have parameter NB_Y, default 8, meaning output width (signed).
REQ-007 SHALL have parameter NBF_Y, default 6, meaning output fractional bits.
REQ-008 SHALL have port i_clock, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-009 SHALL have port i_rst_n, input, 1, meaning asynchronous active-low reset.
REQ-010 SHALL have port i_valid, input, 1, meaning i_x holds a valid sample.
REQ-011 SHALL have port i_x, input, NB_X, meaning the input sample.
REQ-012 SHALL have port o_ready, output, 1, meaning the block accepts a sample this cycle.
REQ-013 SHALL have port o_valid, output, 1, meaning o_y holds a valid result.
REQ-014 SHALL have port o_y, output, NB_Y, meaning the saturated, rounded filter output.
REQ-015 SHALL have port i_ready, input, 1, meaning the downstream consumer accepts o_y.
REQ-016 SHALL have port i_cfg_we, input, 1, meaning coefficient write strobe.
REQ-017 SHALL have port i_cfg_addr, input, clog2(NTAPS), meaning the tap index to write.
REQ-018 SHALL have port i_cfg_data, input, NB_C, meaning the coefficient value.
REQ-019 SHALL have port o_cfg_err, output, 1, meaning a write was rejected (one-cycle pulse).

Function
REQ-020 SHALL implement a 3-state FSM: IDLE, MAC and OUT.
REQ-021 SHALL hold o_ready=1 only in IDLE; a sample is accepted when i_valid&&o_ready.
REQ-022 SHALL, on accept, shift the sample line: x[0]<=i_x, x[k]<=x[k-1], oldest sample discarded; FSM moves to MAC and clears tap counter and accumulator.
REQ-023 SHALL, in MAC, add x[k]*c[k] once per cycle for k=0..NTAPS-1 using one shared signed multiplier, so MAC lasts exactly NTAPS cycles.
REQ-024 SHALL size the product at NB_X+NB_C bits (frac NBF_X+NBF_C) and the accumulator at NB_X+NB_C+clog2(NTAPS) bits, so the accumulator never wraps.
REQ-025 SHALL, on the last MAC cycle, register the quantized accumulator into o_y and enter OUT; o_valid rises NTAPS+1 cycles after the accept edge.
REQ-026 SHALL quantize by round-half-up (add 1 at weight 2^-(NBF_Y+1), then truncate below 2^-NBF_Y), evaluated with one extra guard bit so the rounding carry cannot overflow.
REQ-027 SHALL then saturate: above 2^(NB_Y-1)-1 codes -> 0x7F (default widths); below -2^(NB_Y-1) -> 0x80.
REQ-028 SHALL hold o_valid=1 and keep o_y stable in OUT until i_ready=1; on o_valid&&i_ready, clear o_valid and return to IDLE.
REQ-029 SHALL keep o_y at its last value after the handshake; o_y is meaningful only while o_valid=1.
REQ-030 SHALL apply i_cfg_we only in IDLE; c[i_cfg_addr]<=i_cfg_data takes effect on the next edge.
REQ-031 SHALL, for a write in IDLE coinciding with a sample accept, apply the write, and the accepted sample SHALL use the new coefficient.
REQ-032 SHALL, for i_cfg_we in MAC or OUT, leave the coefficients unchanged and pulse o_cfg_err for one cycle.
REQ-033 SHALL ignore i_valid outside IDLE; the sample line does not change.

Reset
REQ-034 SHALL, while i_rst_n=0, asynchronously force: FSM=IDLE, o_valid=0, o_y=0, o_cfg_err=0, tap counter=0, accumulator=0, all x[k]=0, all c[k]=0.
REQ-035 SHALL, on reset asserted mid-MAC or mid-OUT, abandon the computation; after release o_ready=1 and no stale o_valid appears.

Verification
REQ-036 SHALL cover: c0=64 (0.5), other taps 0, x=32 (0.5) accepted -> o_valid after 5 cycles, o_y=16 (0.25).
REQ-037 SHALL cover rounding: c0=1, x=64 -> o_y=1 (exact half rounds up); c0=1, x=32 -> o_y=0.
REQ-038 SHALL cover saturation: all c=127, four samples x=127 -> fourth result o_y=0x7F; all c=127, four samples x=-128 -> fourth result o_y=0x80.
REQ-039 SHALL cover backpressure: i_ready=0 for 10 cycles in OUT -> o_valid held, o_y stable, o_ready=0, i_valid samples ignored; then i_ready=1 -> IDLE next cycle.
REQ-040 SHALL cover a cfg write during MAC -> o_cfg_err pulses once and the result matches the old coefficients; a write in IDLE coinciding with an accept -> the result uses the new coefficient.
REQ-041 SHALL cover reset pulsed on the 2nd MAC cycle -> o_valid=0, o_ready=1, all coefficients read back as zero (next sample gives o_y=0).
